// File: rtl/uidbufw_rr_pkg.sv
// Shared types and helpers for the uidbuf write-side round-robin interconnect.
package uidbufw_rr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam int FDMA_SIZE_W = 16;

    // Index width for n items; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uidbufw_rr_pick.sv
// Combinational rotating-priority picker: first requester above 'last', with wrap.
module uidbufw_rr_pick
    import uidbufw_rr_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int IDXW   = clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDXW-1:0]   last,
    output logic [IDXW-1:0]   idx,
    output logic              any
);

    logic [IDXW:0] cand;

    // Walk from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = CH_NUM; k >= 1; k--) begin
            cand = {1'b0, last} + (IDXW+1)'(k);
            if (cand >= (IDXW+1)'(CH_NUM)) cand = cand - (IDXW+1)'(CH_NUM);
            if (req[cand[IDXW-1:0]]) begin
                idx = cand[IDXW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uidbufw_rr_interconnect.sv
// N-channel FDMA write interconnect with round-robin grant and registered request.
// Optional request-stall watchdog: define UIDBUFW_RR_TIMEOUT_EN.
module uidbufw_rr_interconnect
    import uidbufw_rr_pkg::*;
#(
    parameter int CH_NUM         = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int REQ_TIMEOUT    = 1023
) (
    input  logic                               ui_clk,
    input  logic                               ui_rstn,
    input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0]   ch_waddr,
    input  logic [CH_NUM-1:0]                  ch_wareq,
    input  logic [CH_NUM*FDMA_SIZE_W-1:0]      ch_wsize,
    output logic [CH_NUM-1:0]                  ch_wbusy,
    input  logic [CH_NUM*AXI_DATA_WIDTH-1:0]   ch_wdata,
    output logic [CH_NUM-1:0]                  ch_wvalid,
    output logic [AXI_ADDR_WIDTH-1:0]          fdma_waddr,
    output logic                               fdma_wareq,
    output logic [FDMA_SIZE_W-1:0]             fdma_wsize,
    input  logic                               fdma_wbusy,
    input  logic                               fdma_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]          fdma_wdata,
    output logic [clog2(CH_NUM)-1:0]           grant_idx,
    output logic                               grant_vld,
    output logic                               arb_err
);

    localparam int IDXW = clog2(CH_NUM);

    state_t              state, state_nxt;
    logic [IDXW-1:0]     last_grant, pick_idx;
    logic                pick_any, timeout;

    logic [AXI_ADDR_WIDTH-1:0] addr_arr [CH_NUM];
    logic [FDMA_SIZE_W-1:0]    size_arr [CH_NUM];
    logic [AXI_DATA_WIDTH-1:0] data_arr [CH_NUM];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_split
        assign addr_arr[i] = ch_waddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign size_arr[i] = ch_wsize[i*FDMA_SIZE_W +: FDMA_SIZE_W];
        assign data_arr[i] = ch_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end

    uidbufw_rr_pick #(
        .CH_NUM (CH_NUM),
        .IDXW   (IDXW)
    ) u_pick (
        .req  (ch_wareq),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef UIDBUFW_RR_TIMEOUT_EN
    localparam int CNTW = clog2(REQ_TIMEOUT + 1);

    logic [CNTW-1:0] req_cnt;

    assign timeout = (state == S_REQ) && !fdma_wbusy && (req_cnt == CNTW'(REQ_TIMEOUT));

    // Counter is zero whenever S_REQ is entered, since S_REQ is only reached from S_IDLE.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            req_cnt <= '0;
            arb_err <= 1'b0;
        end else begin
            req_cnt <= (state == S_REQ) ? req_cnt + 1'b1 : '0;
            if (timeout) arb_err <= 1'b1;
        end
    end
`else
    localparam int unused_req_timeout = REQ_TIMEOUT;

    assign timeout = 1'b0;
    assign arb_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (pick_any) state_nxt = S_REQ;
            S_REQ:   if (fdma_wbusy) state_nxt = S_BUSY;
                     else if (timeout) state_nxt = S_IDLE;
            S_BUSY:  if (!fdma_wbusy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant is captured once in S_IDLE and held through the burst regardless of ch_wareq.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            grant_idx  <= '0;
            last_grant <= IDXW'(CH_NUM - 1);
            fdma_waddr <= '0;
            fdma_wsize <= '0;
        end else if (state == S_IDLE && pick_any) begin
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            fdma_waddr <= addr_arr[pick_idx];
            fdma_wsize <= size_arr[pick_idx];
        end
    end

    always_comb begin
        fdma_wareq = (state == S_REQ);
        grant_vld  = (state != S_IDLE);
        ch_wbusy   = '0;
        ch_wvalid  = '0;
        fdma_wdata = '0;
        if (state != S_IDLE) begin
            ch_wbusy[grant_idx]  = fdma_wbusy;
            ch_wvalid[grant_idx] = fdma_wvalid;
            fdma_wdata           = data_arr[grant_idx];
        end
    end

endmodule
